// File: rtl/lane_memory_pkg.sv
// Shared constants and bus-slicing helpers for the NTT coefficient lane memory.
// Every lane uses the same word width and depth.
package lane_memory_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    // Bit offset of a lane inside the packed data and address buses
    function automatic int data_lo(input int lane);
        return lane * DATA_W;
    endfunction

    function automatic int addr_lo(input int lane);
        return lane * ADDR_W;
    endfunction

endpackage

// File: rtl/lane_memory_mem_bank.sv
// One 256x32 single-port RAM with read-first behaviour and a registered read port.
// The array has no reset so it maps onto block/distributed RAM.
module mem_bank
    import lane_memory_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] ram [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rdata = '0;

    // Reset blocks the write but leaves stored contents alone
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            ram[addr] <= din;
        end
    end

    // Read-first: the register captures the old word on a colliding write
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= ram[addr];
        end
    end

    assign dout = rdata;

endmodule

// File: rtl/lane_memory.sv
// N independent RAM lanes accessed in parallel, one word per butterfly lane per cycle.
// Only packed-bus slicing lives here; each lane is a self-contained mem_bank.
module lane_memory
    import lane_memory_pkg::*;
#(
    parameter int N = 257
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        we,
    input  logic [N*ADDR_W-1:0] addr,
    input  logic [N*DATA_W-1:0] din,
    output logic [N*DATA_W-1:0] dout
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        mem_bank u_bank (
            .clk  (clk),
            .rst  (rst),
            .we   (we[i]),
            .addr (addr[addr_lo(i) +: ADDR_W]),
            .din  (din[data_lo(i) +: DATA_W]),
            .dout (dout[data_lo(i) +: DATA_W])
        );
    end

endmodule

// File: tb/tb_lane_memory.sv
// Self-checking bench for lane_memory: directed scenarios plus randomized traffic
// against an array-based reference of every lane's contents and read register.
module tb_lane_memory;
    import lane_memory_pkg::*;

    localparam int N = 257;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        we;
    logic [N*ADDR_W-1:0] addr;
    logic [N*DATA_W-1:0] din;
    logic [N*DATA_W-1:0] dout;

    logic [DATA_W-1:0] ref_mem [N][DEPTH];
    logic [DATA_W-1:0] ref_dout [N];

    logic              lane_we [N];
    logic [ADDR_W-1:0] lane_addr [N];
    logic [DATA_W-1:0] lane_din [N];

    int checks = 0;
    int failures = 0;

    lane_memory #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] dout_lane(input int i);
        return dout[i*DATA_W +: DATA_W];
    endfunction

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got,
                               input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic set_all(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        for (int i = 0; i < N; i++) begin
            lane_we[i]   = w;
            lane_addr[i] = a;
            lane_din[i]  = d;
        end
    endtask

    // Drive one cycle from the lane arrays, advance the reference at the edge,
    // then compare every lane of dout shortly after the edge.
    task automatic applyStimulus(input logic rst_in, input string tag);
        rst = rst_in;
        for (int i = 0; i < N; i++) begin
            we[i]                    = lane_we[i];
            addr[i*ADDR_W +: ADDR_W] = lane_addr[i];
            din[i*DATA_W +: DATA_W]  = lane_din[i];
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            ref_dout[i] = rst_in ? '0 : ref_mem[i][lane_addr[i]];
            if (lane_we[i] && !rst_in) ref_mem[i][lane_addr[i]] = lane_din[i];
        end
        #1;
        for (int i = 0; i < N; i++) begin
            if (dout_lane(i) !== ref_dout[i]) begin
                checkOutput($sformatf("%s_lane%0d", tag, i), dout_lane(i), ref_dout[i]);
            end else begin
                checks++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ref_dout[i] = '0;
            for (int a = 0; a < DEPTH; a++) ref_mem[i][a] = '0;
        end
        we = '0;
        addr = '0;
        din = '0;
        rst = 1'b1;

        $display("[TB] reset");
        set_all(1'b0, 8'd0, 32'd0);
        applyStimulus(1'b1, "reset");
        checkOutput("reset_lane0", dout_lane(0), 32'h0);
        checkOutput("reset_lane256", dout_lane(256), 32'h0);

        $display("[TB] broadcast write/read");
        set_all(1'b1, 8'd0, 32'd0);
        lane_din[256] = 32'h12345678;
        lane_din[255] = 32'h0000DEAF;
        lane_din[0]   = 32'h00ABCDEF;
        applyStimulus(1'b0, "t1_wr");
        set_all(1'b0, 8'd0, 32'd0);
        applyStimulus(1'b0, "t1_rd");
        checkOutput("t1_lane256", dout_lane(256), 32'h12345678);
        checkOutput("t1_lane255", dout_lane(255), 32'h0000DEAF);
        checkOutput("t1_lane0", dout_lane(0), 32'h00ABCDEF);
        checkOutput("t1_lane100", dout_lane(100), 32'h0);

        $display("[TB] lane independence");
        for (int i = 0; i < N; i++) begin
            lane_we[i]   = 1'b1;
            lane_addr[i] = ADDR_W'(i % DEPTH);
            lane_din[i]  = 32'hAAAA0000 + DATA_W'(i);
        end
        applyStimulus(1'b0, "t2_wr");
        for (int i = 0; i < N; i++) lane_we[i] = 1'b0;
        applyStimulus(1'b0, "t2_rd");
        for (int i = 0; i < N; i += 64) begin
            checkOutput($sformatf("t2_direct%0d", i), dout_lane(i), 32'hAAAA0000 + DATA_W'(i));
        end
        set_all(1'b0, 8'd7, 32'd0);
        applyStimulus(1'b0, "t2_addr7");
        checkOutput("t2_lane3_addr7", dout_lane(3), 32'h0);
        checkOutput("t2_lane7_addr7", dout_lane(7), 32'hAAAA0007);

        $display("[TB] read-first collision");
        set_all(1'b0, 8'd5, 32'd0);
        lane_we[0]  = 1'b1;
        lane_din[0] = 32'h11111111;
        applyStimulus(1'b0, "t3_pre");
        lane_din[0] = 32'h22222222;
        applyStimulus(1'b0, "t3_coll");
        checkOutput("t3_old", dout_lane(0), 32'h11111111);
        lane_we[0] = 1'b0;
        applyStimulus(1'b0, "t3_after");
        checkOutput("t3_new", dout_lane(0), 32'h22222222);

        $display("[TB] partial write enable");
        set_all(1'b0, 8'd9, 32'hFFFFFFFF);
        lane_we[1] = 1'b1;
        applyStimulus(1'b0, "t4_wr");
        set_all(1'b0, 8'd9, 32'd0);
        applyStimulus(1'b0, "t4_rd");
        checkOutput("t4_lane1", dout_lane(1), 32'hFFFFFFFF);
        checkOutput("t4_lane9", dout_lane(9), 32'hAAAA0009);
        checkOutput("t4_lane2", dout_lane(2), 32'h0);

        $display("[TB] reset mid-operation");
        set_all(1'b0, 8'd5, 32'd0);
        applyStimulus(1'b0, "t5_pre");
        checkOutput("t5_before_rst", dout_lane(0), 32'h22222222);
        lane_we[0]  = 1'b1;
        lane_din[0] = 32'h33333333;
        applyStimulus(1'b1, "t5_rst");
        checkOutput("t5_cleared", dout_lane(0), 32'h0);
        lane_we[0] = 1'b0;
        applyStimulus(1'b0, "t5_after");
        checkOutput("t5_preserved", dout_lane(0), 32'h22222222);

        $display("[TB] boundary addresses");
        set_all(1'b0, 8'd0, 32'd0);
        lane_we[128]  = 1'b1;
        lane_din[128] = 32'hCAFE0000;
        applyStimulus(1'b0, "t6_wr0");
        lane_addr[128] = 8'd255;
        lane_din[128]  = 32'hBEEF00FF;
        applyStimulus(1'b0, "t6_wr255");
        lane_we[128]   = 1'b0;
        lane_addr[128] = 8'd0;
        applyStimulus(1'b0, "t6_rd0");
        checkOutput("t6_addr0", dout_lane(128), 32'hCAFE0000);
        lane_addr[128] = 8'd255;
        applyStimulus(1'b0, "t6_rd255");
        checkOutput("t6_addr255", dout_lane(128), 32'hBEEF00FF);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                lane_we[i]   = ($urandom_range(3) == 0);
                lane_addr[i] = (c < 150) ? ADDR_W'($urandom_range(3))
                                         : ADDR_W'($urandom_range(DEPTH - 1));
                lane_din[i]  = $urandom;
            end
            applyStimulus($urandom_range(19) == 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lane_memory.md
Name: lane_memory

Overview:
- Array of N independent single-port RAM lanes, each 256 words x 32 bits, with per-lane address, write enable, write data and read data.
- All lanes are accessed in parallel in the same clock cycle.
- Serves as coefficient storage for the NTT datapath, giving one word per butterfly lane per cycle.

Parameters:
- N, 257, number of independent lanes/banks.
- DATA_W, 32, word width per lane.
- ADDR_W, 8, address width per lane; depth = 2**ADDR_W = 256 words.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- we  input  N  per-lane write enable; bit i controls lane i.
- addr  input  N*ADDR_W  packed addresses; lane i = addr[i*ADDR_W +: ADDR_W].
- din  input  N*DATA_W  packed write data; lane i = din[i*DATA_W +: DATA_W].
- dout  output  N*DATA_W  packed registered read data; lane i = dout[i*DATA_W +: DATA_W].

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Lanes are fully independent. No cross-lane interaction; the same address in different lanes refers to different storage.
- Write: at a rising clk edge with we[i]=1, lane i stores din lane i at the location given by addr lane i.
- Read, 1-cycle latency: at every rising edge (rst=0), dout lane i is loaded with the word at addr lane i. The read happens regardless of we.
- Read-during-write on the same lane and edge is read-first: dout gets the OLD contents and the new data is stored. The new value is visible from the next read.
- we=0: the lane's contents are unchanged; dout still updates from addr.
- Reset (rst=1 at an edge):
  - dout is cleared to all zeros.
  - RAM contents are NOT cleared.
  - Writes with we=1 are suppressed in that cycle.
  - Reset mid-operation loses only the in-flight read result.
- Power-up: RAM contents are initialised to zero, which maps to the initial value in simulation and to the BRAM init on FPGA. dout powers up as zero.
- Address range: every ADDR_W-bit value is valid. There are no out-of-range conditions and no wrap logic.
- No handshake, no stall, no error outputs. Combinational path from inputs to dout is prohibited.
- Storage must be inferable as block/distributed RAM per lane: one write port and one synchronous read port per lane, with no reset on the array.

Decomposition:
- Shared package lane_memory_pkg: DATA_W=32, ADDR_W=8 and DEPTH=256 localparams.
- Lane-slice helper functions for packed-bus indexing.
- Natural sub-module: mem_bank. One 256x32 single-port, read-first RAM with a synchronously reset output register.
- lane_memory is a generate loop of N mem_bank instances plus bus slicing.

Test Plan:
1. Broadcast write/read, N=257:
   - Stimulus: one cycle with we=all ones, addr=0 in every lane, din lane 256=0x12345678, lane 255=0x0000DEAF, lanes 1..254=0, lane 0=0x00ABCDEF. Then we=0 and read addr=0.
   - Required: next edge gives dout lane 256=0x12345678, lane 255=0x0000DEAF, lane 0=0x00ABCDEF, all other lanes 0.
2. Lane independence:
   - Stimulus: write 0xAAAA0000+i to lane i at address i mod 256. Then read all lanes at address i mod 256.
   - Required: lane i returns 0xAAAA0000+i. Reading address 7 in lane 3 returns 0, confirming only lane 7 holds data at address 7.
3. Read-first collision:
   - Stimulus: lane 0 holds 0x11111111 at address 5. Write 0x22222222 to address 5 with a simultaneous read of address 5.
   - Required: dout lane 0=0x11111111 that cycle, 0x22222222 on the following cycle.
4. Partial write enable:
   - Stimulus: we only bit 1 set, all lanes at address 9 with din=0xFFFFFFFF.
   - Required: a read of address 9 returns 0xFFFFFFFF in lane 1 only; other lanes hold their prior values.
5. Reset:
   - Stimulus: assert rst for one edge while reading a non-zero location.
   - Required: dout becomes 0 after that edge. Contents are preserved: the next read returns the stored value. A write issued during rst is not stored.
6. Boundary addresses:
   - Stimulus: write to addresses 0 and 255 in lane 128, then read both back.
   - Required: exact data returned; no aliasing between addresses 0 and 255.
